// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM receive path.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT    = 1'b0,
        ALIGNED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position within a TDM frame: load-to-1 on a frame marker, step on each slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    logic [SLOT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SLOT_W'(1);
        end else if (inc) begin
            cnt <= cnt + SLOT_W'(1);
        end
    end

    assign slot = cnt;
    assign last = (cnt == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux_4ch.sv
// Receive side of the 4-slot TDM link: frames a serial slot stream into four
// channel registers and flags framing violations.
//
//   state   | meaning
//   HUNT    | waiting for a valid sample carrying frame_sync
//   ALIGNED | tracking slots; slot counter gives the expected position
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             out_valid,
    output logic             sync_err,
    output logic             aligned
);

    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] slot;
    logic              last;
    logic              ctr_load1;
    logic              ctr_inc;
    logic              cap_slot0;
    logic              cap_slot;
    logic              frame_done;
    logic              err_nxt;
    logic [WIDTH-1:0]  shadow [NUM_CH-1];

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ctr_load1  = 1'b0;
        ctr_inc    = 1'b0;
        cap_slot0  = 1'b0;
        cap_slot   = 1'b0;
        frame_done = 1'b0;
        err_nxt    = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        cap_slot0 = 1'b1;
                        ctr_load1 = 1'b1;
                        state_nxt = ALIGNED;
                    end
                end
                ALIGNED: begin
                    if (frame_sync) begin
                        // An early marker restarts the frame on this sample.
                        cap_slot0 = 1'b1;
                        ctr_load1 = 1'b1;
                        err_nxt   = (slot != '0);
                    end else if (slot == '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        cap_slot   = 1'b1;
                        ctr_inc    = 1'b1;
                        frame_done = last;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                shadow[i] <= '0;
            end
            ch0       <= '0;
            ch1       <= '0;
            ch2       <= '0;
            ch3       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            aligned   <= 1'b0;
        end else begin
            out_valid <= frame_done;
            sync_err  <= err_nxt;
            aligned   <= (state_nxt == ALIGNED);
            if (cap_slot0) begin
                shadow[0] <= din;
            end
            if (cap_slot) begin
                case (slot)
                    SLOT_W'(1): shadow[1] <= din;
                    SLOT_W'(2): shadow[2] <= din;
                    default: ;
                endcase
            end
            // Slot 3 goes straight from din so the whole frame lands on one edge.
            if (frame_done) begin
                ch0 <= shadow[0];
                ch1 <= shadow[1];
                ch2 <= shadow[2];
                ch3 <= din;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed frames with literal expectations plus
// randomized traffic checked every cycle against a frame-level model.
module tb_tdm_demux_4ch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         out_valid, sync_err, aligned;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model: frame position as a plain integer, samples collected in an array.
    bit           m_al;
    int           m_pos;
    logic [W-1:0] m_buf [4];
    logic [W-1:0] m_ch  [4];
    bit           m_ov;
    bit           m_err;

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .out_valid  (out_valid),
        .sync_err   (sync_err),
        .aligned    (aligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_al  = 1'b0;
            m_pos = 0;
            for (int i = 0; i < 4; i++) begin
                m_buf[i] = '0;
                m_ch[i]  = '0;
            end
        end else if (din_valid) begin
            if (frame_sync) begin
                if (m_al && m_pos != 0) m_err = 1'b1;
                m_buf[0] = din;
                m_pos    = 1;
                m_al     = 1'b1;
            end else if (m_al) begin
                if (m_pos == 0) begin
                    m_err = 1'b1;
                    m_al  = 1'b0;
                end else begin
                    m_buf[m_pos] = din;
                    m_pos++;
                    if (m_pos == 4) begin
                        m_ch  = m_buf;
                        m_ov  = 1'b1;
                        m_pos = 0;
                    end
                end
            end
        end
    endtask

    // One clock: apply inputs, advance model on the edge, return at the next falling edge.
    task automatic cyc(input bit r, input bit v, input bit fs, input logic [W-1:0] d);
        rst        = r;
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input bit fs);
        cyc(1'b0, 1'b1, fs, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, W'($urandom));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b1, 8'hff);
    endtask

    task automatic frame(input logic [W-1:0] base);
        send(base, 1'b1);
        send(base + 8'd1, 1'b0);
        send(base + 8'd2, 1'b0);
        send(base + 8'd3, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ch0", ch0, m_ch[0]);
            chk("ch1", ch1, m_ch[1]);
            chk("ch2", ch2, m_ch[2]);
            chk("ch3", ch3, m_ch[3]);
            chk("out_valid", out_valid, m_ov);
            chk("sync_err", sync_err, m_err);
            chk("aligned", aligned, m_al);
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk_on = 1'b1;
        chk("rst_ch0", ch0, 8'h00);
        chk("rst_ch3", ch3, 8'h00);
        chk("rst_aligned", aligned, 1'b0);

        // Plain aligned frame
        cyc(1'b0, 1'b0, 1'b0, '0);
        send(8'h11, 1'b1);
        chk("t1_aligned", aligned, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("t1_no_ov_early", out_valid, 1'b0);
        send(8'h44, 1'b0);
        chk("t1_ov", out_valid, 1'b1);
        chk("t1_ch0", ch0, 8'h11);
        chk("t1_ch1", ch1, 8'h22);
        chk("t1_ch2", ch2, 8'h33);
        chk("t1_ch3", ch3, 8'h44);
        chk("t1_err", sync_err, 1'b0);
        idle();
        chk("t1_ov_pulse", out_valid, 1'b0);

        // Frames with mid-frame gaps
        send(8'hA0, 1'b1); send(8'hA1, 1'b0); idle(); send(8'hA2, 1'b0); idle(); idle();
        send(8'hA3, 1'b0);
        chk("t2_ovA", out_valid, 1'b1);
        chk("t2_chA0", ch0, 8'hA0);
        chk("t2_chA3", ch3, 8'hA3);
        send(8'hB0, 1'b1); send(8'hB1, 1'b0); idle(); send(8'hB2, 1'b0);
        chk("t2_hold0", ch0, 8'hA0);
        chk("t2_hold2", ch2, 8'hA2);
        send(8'hB3, 1'b0);
        chk("t2_ovB", out_valid, 1'b1);
        chk("t2_chB0", ch0, 8'hB0);
        chk("t2_chB3", ch3, 8'hB3);

        // Early sync
        send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b1);
        chk("t3_err", sync_err, 1'b1);
        chk("t3_hold", ch0, 8'hB0);
        send(8'h04, 1'b0);
        chk("t3_err_pulse", sync_err, 1'b0);
        send(8'h05, 1'b0); send(8'h06, 1'b0);
        chk("t3_ov", out_valid, 1'b1);
        chk("t3_ch0", ch0, 8'h03);
        chk("t3_ch1", ch1, 8'h04);
        chk("t3_ch3", ch3, 8'h06);

        // Missing sync
        frame(8'hC0);
        chk("t4_ch1", ch1, 8'hC1);
        send(8'h77, 1'b0);
        chk("t4_err", sync_err, 1'b1);
        chk("t4_hunt", aligned, 1'b0);
        send(8'h88, 1'b0);
        chk("t4_quiet", sync_err, 1'b0);
        chk("t4_still_hunt", aligned, 1'b0);
        send(8'h90, 1'b1);
        chk("t4_realign", aligned, 1'b1);
        send(8'h91, 1'b0); send(8'h92, 1'b0); send(8'h93, 1'b0);
        chk("t4_ch0", ch0, 8'h90);
        chk("t4_ch2", ch2, 8'h92);

        // HUNT after reset drops unsynced samples silently
        do_reset();
        send(8'h55, 1'b0);
        chk("t5_err0", sync_err, 1'b0);
        send(8'h66, 1'b0);
        chk("t5_err1", sync_err, 1'b0);
        chk("t5_ov", out_valid, 1'b0);
        frame(8'h60);
        chk("t5_ch0", ch0, 8'h60);
        chk("t5_ch3", ch3, 8'h63);

        // Reset mid-frame
        send(8'hD0, 1'b1); send(8'hD1, 1'b0); send(8'hD2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hD3);
        chk("t6_ch0", ch0, 8'h00);
        chk("t6_ch3", ch3, 8'h00);
        chk("t6_aligned", aligned, 1'b0);
        frame(8'hE0);
        chk("t6_ch0_after", ch0, 8'hE0);
        chk("t6_ch3_after", ch3, 8'hE3);

        // Randomized traffic, marker biased toward the expected slot
        for (int n = 0; n < 4000; n++) begin
            bit r, v, fs;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 99) < 75);
            fs = ($urandom_range(0, 99) < ((m_pos == 0) ? 85 : 6));
            cyc(r, v, fs, W'($urandom));
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
